// File: rtl/bus_activity_monitor.sv
// bus_activity_monitor: watches the CPU bus request/grant/transfer handshake and
// produces registered busIdle, grantWait and transferActive qualifiers for the
// profiler, plus a wrapping count of completed transfers.
// Optional transfer watchdog: define BUS_WATCHDOG_EN to abort transfers that run
// for WATCHDOG_CYCLES cycles and pulse timeoutErr; otherwise timeoutErr is tied 0.
module bus_activity_monitor #(
  parameter int IDLE_HOLD       = 2,
  parameter int COUNT_WIDTH     = 16,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   request,
  input  logic                   grant,
  input  logic                   beginTransaction,
  input  logic                   endTransaction,
  input  logic                   busError,
  output logic                   busIdle,
  output logic                   grantWait,
  output logic                   transferActive,
  output logic [COUNT_WIDTH-1:0] transferCount,
  output logic                   timeoutErr
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GRANT,
    GRANTED,
    TRANSFER
  } state_t;

  localparam logic [3:0] HOLD = 4'(IDLE_HOLD);

  state_t     state;
  state_t     state_nxt;
  logic       count_inc;
  logic       watchdog_fire;
  logic [3:0] idle_cnt;
  logic [3:0] idle_cnt_nxt;

`ifdef BUS_WATCHDOG_EN
  localparam int WD_W = (WATCHDOG_CYCLES > 2) ? $clog2(WATCHDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // A stalled transfer is aborted only when no end/error arrives on the same edge.
  always_comb begin
    watchdog_fire = 1'b0;
    if (state == TRANSFER && !endTransaction && !busError && wd_cnt == WD_LAST) begin
      watchdog_fire = 1'b1;
    end
  end

  // Watchdog age counts edges spent in TRANSFER and restarts on every new entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt     <= '0;
      timeoutErr <= 1'b0;
    end else begin
      timeoutErr <= watchdog_fire;
      if (state == TRANSFER && state_nxt == TRANSFER) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end else begin
        wd_cnt <= '0;
      end
    end
  end
`else
  assign watchdog_fire = 1'b0;
  assign timeoutErr    = 1'b0;
`endif

  // Next-state and completion decode for the bus handshake.
  always_comb begin
    state_nxt = state;
    count_inc = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          state_nxt = grant ? GRANTED : WAIT_GRANT;
        end
      end
      WAIT_GRANT: begin
        if (!request) begin
          state_nxt = IDLE;
        end else if (grant) begin
          state_nxt = GRANTED;
        end
      end
      GRANTED: begin
        if (beginTransaction && endTransaction) begin
          count_inc = 1'b1;
          state_nxt = request ? GRANTED : IDLE;
        end else if (beginTransaction) begin
          state_nxt = TRANSFER;
        end else if (!request) begin
          state_nxt = IDLE;
        end
      end
      TRANSFER: begin
        if (busError) begin
          state_nxt = request ? GRANTED : IDLE;
        end else if (endTransaction) begin
          count_inc = 1'b1;
          state_nxt = request ? GRANTED : IDLE;
        end else if (watchdog_fire) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Quiet-cycle counter saturates at the hold threshold and clears on any activity.
  always_comb begin
    idle_cnt_nxt = 4'd0;
    if (state == IDLE && !request) begin
      idle_cnt_nxt = (idle_cnt == HOLD) ? idle_cnt : idle_cnt + 4'd1;
    end
  end

  // State register with outputs registered from the next-state decode.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      idle_cnt       <= 4'd0;
      busIdle        <= 1'b0;
      grantWait      <= 1'b0;
      transferActive <= 1'b0;
      transferCount  <= '0;
    end else begin
      state          <= state_nxt;
      idle_cnt       <= idle_cnt_nxt;
      busIdle        <= (idle_cnt_nxt == HOLD);
      grantWait      <= (state_nxt == WAIT_GRANT);
      transferActive <= (state_nxt == TRANSFER);
      if (count_inc) begin
        transferCount <= transferCount + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_bus_activity_monitor.sv
// tb_bus_activity_monitor: directed and randomized stimulus for bus_activity_monitor,
// compared every cycle against a flag-based reference model of the bus handshake.
module tb_bus_activity_monitor;

  localparam int IDLE_HOLD = 2;
  localparam int WD_CYCLES = 8;
`ifdef BUS_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        request;
  logic        grant;
  logic        beginTransaction;
  logic        endTransaction;
  logic        busError;
  logic        busIdle;
  logic        grantWait;
  logic        transferActive;
  logic [15:0] transferCount;
  logic        timeoutErr;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a few booleans describing who owns the bus.
  bit          mWaiting;
  bit          mOwned;
  bit          mInXfer;
  int          mQuiet;
  int          mAge;
  logic [15:0] mCount;
  bit          mTimeout;

  int pulses;
  int pulseAt;
  int waitCycles;

  bus_activity_monitor #(
    .IDLE_HOLD       (IDLE_HOLD),
    .COUNT_WIDTH     (16),
    .WATCHDOG_CYCLES (WD_CYCLES)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .request          (request),
    .grant            (grant),
    .beginTransaction (beginTransaction),
    .endTransaction   (endTransaction),
    .busError         (busError),
    .busIdle          (busIdle),
    .grantWait        (grantWait),
    .transferActive   (transferActive),
    .transferCount    (transferCount),
    .timeoutErr       (timeoutErr)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic modelReset();
    mWaiting = 0;
    mOwned   = 0;
    mInXfer  = 0;
    mQuiet   = 0;
    mAge     = 0;
    mCount   = 16'h0000;
    mTimeout = 0;
  endtask

  task automatic modelEdge(input logic req, input logic gnt, input logic beg,
                           input logic endT, input logic err);
    bit onIdleBus;
    onIdleBus = !mWaiting && !mOwned && !mInXfer;
    if (onIdleBus && !req) mQuiet = mQuiet + 1;
    else mQuiet = 0;
    mTimeout = 0;
    if (mInXfer) begin
      if (err || endT) begin
        if (!err) mCount = mCount + 16'd1;
        mInXfer = 0;
        mOwned  = req;
      end else if (WD_ON && mAge == WD_CYCLES - 1) begin
        mInXfer  = 0;
        mTimeout = 1;
      end else begin
        mAge = mAge + 1;
      end
    end else if (mOwned) begin
      if (beg && endT) begin
        mCount = mCount + 16'd1;
        mOwned = req;
      end else if (beg) begin
        mOwned  = 0;
        mInXfer = 1;
        mAge    = 0;
      end else if (!req) begin
        mOwned = 0;
      end
    end else if (mWaiting) begin
      if (!req) mWaiting = 0;
      else if (gnt) begin
        mWaiting = 0;
        mOwned   = 1;
      end
    end else if (req) begin
      if (gnt) mOwned = 1;
      else mWaiting = 1;
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    end
  endtask

  task automatic checkValue(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkBit({tag, ".busIdle"}, busIdle, (mQuiet >= IDLE_HOLD));
    checkBit({tag, ".grantWait"}, grantWait, mWaiting);
    checkBit({tag, ".transferActive"}, transferActive, mInXfer);
    checkBit({tag, ".timeoutErr"}, timeoutErr, mTimeout);
    checkValue({tag, ".transferCount"}, transferCount, mCount);
  endtask

  task automatic applyStimulus(input logic req, input logic gnt, input logic beg,
                               input logic endT, input logic err, input string tag);
    request          = req;
    grant            = gnt;
    beginTransaction = beg;
    endTransaction   = endT;
    busError         = err;
    @(posedge clock);
    modelEdge(req, gnt, beg, endT, err);
    #1;
    checkOutput(tag);
  endtask

  task automatic resetPulse(input string tag);
    request          = 1'b0;
    grant            = 1'b0;
    beginTransaction = 1'b0;
    endTransaction   = 1'b0;
    busError         = 1'b0;
    reset            = 1'b0;
    #1;
    modelReset();
    checkOutput(tag);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    request          = 1'b0;
    grant            = 1'b0;
    beginTransaction = 1'b0;
    endTransaction   = 1'b0;
    busError         = 1'b0;
    reset            = 1'b0;
    #2;
    modelReset();
    checkOutput("resetState");
    #1;
    reset = 1'b1;

    // Quiet bus after reset, then async reset in the middle of the idle window.
    applyStimulus(0, 0, 0, 0, 0, "idleEdge1");
    checkBit("idleEdge1.const", busIdle, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, "idleEdge2");
    checkBit("idleEdge2.const", busIdle, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, "idleEdge3");
    resetPulse("midWindowReset");
    checkBit("midWindowReset.const", busIdle, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, "postReset1");
    applyStimulus(0, 0, 0, 0, 0, "postReset2");

    // Request without grant for four edges, then grant.
    waitCycles = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, "grantWait");
      if (grantWait === 1'b1) waitCycles++;
    end
    applyStimulus(1, 1, 0, 0, 0, "granted");
    checkBit("granted.grantWaitLow", grantWait, 1'b0);
    checkValue("grantWaitCycles", 16'(waitCycles), 16'd4);

    // Multi-cycle transfer finished with request dropped.
    applyStimulus(1, 1, 1, 0, 0, "xferBegin");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 0, 0, "xferBody");
    applyStimulus(0, 0, 0, 1, 0, "xferEnd");
    checkValue("xferEnd.count", transferCount, 16'd1);
    applyStimulus(0, 0, 0, 0, 0, "xferQuiet1");
    applyStimulus(0, 0, 0, 0, 0, "xferQuiet2");
    checkBit("xferQuiet2.busIdle", busIdle, 1'b1);

    // End and error together: error wins, no count.
    applyStimulus(1, 1, 0, 0, 0, "errGrant");
    applyStimulus(1, 1, 1, 0, 0, "errBegin");
    applyStimulus(1, 1, 0, 1, 1, "errAndEnd");
    checkValue("errAndEnd.count", transferCount, 16'd1);

    // Single-cycle transfer inside GRANTED never shows transferActive.
    applyStimulus(1, 1, 1, 1, 0, "singleCycle");
    checkValue("singleCycle.count", transferCount, 16'd2);
    checkBit("singleCycle.active", transferActive, 1'b0);

    // Begin beats a withdrawn request in GRANTED.
    applyStimulus(0, 0, 1, 0, 0, "beginBeatsDrop");
    applyStimulus(0, 0, 0, 0, 1, "errorAbort");

    // Stalled transfer: watchdog abort if built in, otherwise waits forever.
    resetPulse("wdReset");
    applyStimulus(1, 1, 0, 0, 0, "wdGrant");
    applyStimulus(1, 1, 1, 0, 0, "wdBegin");
    pulses  = 0;
    pulseAt = 0;
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1, 0, 0, 0, 0, "wdStall");
      if (timeoutErr === 1'b1) begin
        pulses++;
        pulseAt = i;
      end
    end
`ifdef BUS_WATCHDOG_EN
    checkValue("wdPulseCount", 16'(pulses), 16'd1);
    checkValue("wdPulseCycle", 16'(pulseAt), 16'(WD_CYCLES));
`else
    checkValue("wdPulseCount", 16'(pulses), 16'd0);
    checkBit("wdStillActive", transferActive, 1'b1);
`endif

    // Drive transferCount to all-ones, then one more transfer wraps it to zero.
    resetPulse("wrapReset");
    for (int i = 0; i < 70000 && mCount != 16'hFFFF; i++) begin
      applyStimulus(1, 1, 1, 1, 0, "wrapFill");
    end
    checkValue("wrapFull", transferCount, 16'hFFFF);
    applyStimulus(1, 1, 1, 1, 0, "wrapStep");
    checkValue("wrapToZero", transferCount, 16'h0000);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        resetPulse("randReset");
      end else begin
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 7) == 0, "random");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
